tone_scheduler: RTL

//  Sequences the buzzer/speaker datapath: arbitrates DO/RE/MI note requests and an
//  8-note auto-play melody onto a single tone channel, and owns the volume level.

---
 rtl/tone_scheduler_if.sv | 29 ++
 rtl/tone_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tone_scheduler_if.sv
// Button-pulse inputs and tone/volume outputs of the tone scheduler.
// Inputs are single-cycle pulses; there is no backpressure in either direction.
interface tone_scheduler_if;
  logic        req_do;
  logic        req_re;
  logic        req_mi;
  logic        vol_up;
  logic        vol_dn;
  logic        play;
  logic [21:0] note_div;
  logic        note_on;
  logic [15:0] amp_hi;
  logic [15:0] amp_lo;
  logic [3:0]  vol;
  logic [3:0]  vol_tens;
  logic [3:0]  vol_ones;
  logic [2:0]  mel_idx;
  logic [1:0]  state;

  modport master (
    output req_do, req_re, req_mi, vol_up, vol_dn, play,
    input  note_div, note_on, amp_hi, amp_lo, vol, vol_tens, vol_ones, mel_idx, state
  );

  modport slave (
    input  req_do, req_re, req_mi, vol_up, vol_dn, play,
    output note_div, note_on, amp_hi, amp_lo, vol, vol_tens, vol_ones, mel_idx, state
  );
endinterface

// File: rtl/tone_scheduler.sv
// Arbitrates manual DO/RE/MI requests and an 8-note melody onto one tone channel,
// and owns the volume level with its amplitude pair and decimal digits.
module tone_scheduler #(
  parameter int          NOTE_TICKS = 25_000_000,
  parameter int          GAP_TICKS  = 5_000_000,
  parameter logic [3:0]  VOL_INIT   = 4'd8
) (
  input  logic            clk,
  input  logic            rst,
  tone_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MANUAL   = 2'd1,
    MEL_NOTE = 2'd2,
    MEL_GAP  = 2'd3
  } state_t;

  localparam int CNT_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_TICKS - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS - 1);

  localparam logic [21:0] DIV_DO = 22'd190839;
  localparam logic [21:0] DIV_RE = 22'd170068;
  localparam logic [21:0] DIV_MI = 22'd151515;

  localparam logic [15:0] AMP_INIT  = {1'b0, VOL_INIT, 11'b0};
  localparam logic [15:0] AMPN_INIT = 16'd0 - AMP_INIT;
  localparam logic [3:0]  TENS_INIT = (VOL_INIT >= 4'd10) ? 4'd1 : 4'd0;
  localparam logic [3:0]  ONES_INIT = (VOL_INIT >= 4'd10) ? VOL_INIT - 4'd10 : VOL_INIT;

  function automatic logic [21:0] mel_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd5, 3'd7: mel_rom = DIV_DO;
      3'd1, 3'd4, 3'd6: mel_rom = DIV_RE;
      default:          mel_rom = DIV_MI;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [21:0]    div_q, div_d;
  logic           on_q, on_d;
  logic [2:0]     mel_q, mel_d;
  logic [3:0]     vol_q, vol_d;
  logic [15:0]    amp_hi_q, amp_hi_d, amp_lo_q, amp_lo_d;
  logic [3:0]     tens_q, tens_d, ones_q, ones_d;
  logic           req_any;
  logic [21:0]    req_div;

  assign req_any = bus.req_do | bus.req_re | bus.req_mi;
  assign req_div = bus.req_do ? DIV_DO : (bus.req_re ? DIV_RE : DIV_MI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      on_q     <= 1'b0;
      mel_q    <= '0;
      vol_q    <= VOL_INIT;
      amp_hi_q <= AMP_INIT;
      amp_lo_q <= AMPN_INIT;
      tens_q   <= TENS_INIT;
      ones_q   <= ONES_INIT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      on_q     <= on_d;
      mel_q    <= mel_d;
      vol_q    <= vol_d;
      amp_hi_q <= amp_hi_d;
      amp_lo_q <= amp_lo_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    on_d    = on_q;
    mel_d   = mel_q;

    case (state_q)
      IDLE, MANUAL: begin
        // play wins over any note request arriving in the same cycle
        if (bus.play) begin
          state_d = MEL_NOTE;
          mel_d   = 3'd0;
          div_d   = mel_rom(3'd0);
          on_d    = 1'b1;
          cnt_d   = NOTE_LOAD;
        end else if (req_any) begin
          state_d = MANUAL;
          div_d   = req_div;
          on_d    = 1'b1;
          cnt_d   = NOTE_LOAD;
        end else if (state_q == MANUAL) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            on_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      MEL_NOTE, MEL_GAP: begin
        if (bus.play) begin
          state_d = IDLE;
          on_d    = 1'b0;
          mel_d   = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (state_q == MEL_NOTE) begin
          state_d = MEL_GAP;
          on_d    = 1'b0;
          cnt_d   = GAP_LOAD;
        end else if (mel_q != 3'd7) begin
          state_d = MEL_NOTE;
          mel_d   = mel_q + 3'd1;
          div_d   = mel_rom(mel_q + 3'd1);
          on_d    = 1'b1;
          cnt_d   = NOTE_LOAD;
        end else begin
          state_d = IDLE;
          mel_d   = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Volume path runs independently of the tone FSM; up+dn together cancel.
  always_comb begin
    vol_d = vol_q;
    if (bus.vol_up && !bus.vol_dn && vol_q != 4'd15)
      vol_d = vol_q + 4'd1;
    else if (bus.vol_dn && !bus.vol_up && vol_q != 4'd0)
      vol_d = vol_q - 4'd1;
    amp_hi_d = {1'b0, vol_d, 11'b0};
    amp_lo_d = 16'd0 - amp_hi_d;
    tens_d   = (vol_d >= 4'd10) ? 4'd1 : 4'd0;
    ones_d   = (vol_d >= 4'd10) ? vol_d - 4'd10 : vol_d;
  end

  assign bus.note_div = div_q;
  assign bus.note_on  = on_q;
  assign bus.amp_hi   = amp_hi_q;
  assign bus.amp_lo   = amp_lo_q;
  assign bus.vol      = vol_q;
  assign bus.vol_tens = tens_q;
  assign bus.vol_ones = ones_q;
  assign bus.mel_idx  = mel_q;
  assign bus.state    = state_q;

endmodule
